// File: rtl/checker9_stim_if.sv
// Bus between the checker9 vector transmitter and its controller / FSM under test.
//   master : loads the buffer (wr_en, wr_x, wr_y), controls the run (clr, start, hold),
//            supplies the FSM response (y_in) and observes status
//   slave  : the transmitter itself (checker9_stim)
interface checker9_stim_if #(
   parameter int XW = 10,
   parameter int YW = 11,
   parameter int AW = 4,
   parameter int HW = 4
);
   logic          wr_en;
   logic [XW-1:0] wr_x;
   logic [YW-1:0] wr_y;
   logic          clr;
   logic          start;
   logic [HW-1:0] hold;
   logic [YW-1:0] y_in;
   logic [XW-1:0] x_out;
   logic          full;
   logic [AW:0]   count;
   logic          busy;
   logic          done;
   logic [AW:0]   mis_cnt;
   logic          fail_vld;
   logic [AW-1:0] fail_idx;

   modport master (
      output wr_en, wr_x, wr_y, clr, start, hold, y_in,
      input  x_out, full, count, busy, done, mis_cnt, fail_vld, fail_idx
   );

   modport slave (
      input  wr_en, wr_x, wr_y, clr, start, hold, y_in,
      output x_out, full, count, busy, done, mis_cnt, fail_vld, fail_idx
   );
endinterface

// File: rtl/checker9_stim.sv
// Vector transmitter for the checker9 FSM benchmark. Software loads up to DEPTH
// (stimulus, expected-response) pairs, then starts a run; each stimulus is held
// on x_out for H cycles, y_in is sampled at the end of the window and compared.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : checker9_stim_if.slave (load, control, x/y buses, status)
//
// state  | meaning
// IDLE   | buffer loading allowed, no result held
// RUN    | replaying vectors, busy=1
// DONE   | run finished, results held, buffer retained for replay
module checker9_stim #(
   parameter int XW    = 10,
   parameter int YW    = 11,
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int HW    = 4
) (
   input logic           clk,
   input logic           rst,
   checker9_stim_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t state, state_nx;

   logic [XW+YW-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
   logic [AW:0]      cnt, mis;
   logic [HW-1:0]    h_lat, hcnt;
   logic [XW-1:0]    xo;
   logic [AW-1:0]    fidx;
   logic             fvld;
   // first RUN cycle: x[0] is put on the bus one edge after start
   logic             prime;

   logic idle_like, full, do_start, do_wr, last;
   logic [YW-1:0] exp_y;

   always_comb begin
      idle_like = (state == S_IDLE) || (state == S_DONE);
      full      = (cnt == FULL_CNT);
      do_start  = idle_like && bus.start && !bus.clr;
      do_wr     = idle_like && bus.wr_en && !full && !bus.start && !bus.clr;
      last      = ({1'b0, rd_ptr} == (cnt - 1'b1));
      rd_nxt    = rd_ptr + 1'b1;
      exp_y     = mem[rd_ptr][YW-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.clr) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: if (do_start) state_nx = (cnt == '0) ? S_DONE : S_RUN;
            S_RUN:          if (!prime && hcnt == '0 && last) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
         endcase
      end
   end

   // buffer contents are not reset
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= {bus.wr_x, bus.wr_y};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         mis    <= '0;
         fvld   <= 1'b0;
         fidx   <= '0;
         h_lat  <= HW'(1);
         hcnt   <= '0;
         xo     <= '0;
         prime  <= 1'b0;
      end else if (bus.clr) begin
         // x_out deliberately keeps its value
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         mis    <= '0;
         fvld   <= 1'b0;
         fidx   <= '0;
         prime  <= 1'b0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= cnt + 1'b1;
         end
         if (do_start) begin
            h_lat  <= (bus.hold == '0) ? HW'(1) : bus.hold;
            rd_ptr <= '0;
            mis    <= '0;
            fvld   <= 1'b0;
            fidx   <= '0;
            prime  <= 1'b1;
         end else if (state == S_RUN) begin
            if (prime) begin
               prime <= 1'b0;
               xo    <= mem[0][XW+YW-1:YW];
               hcnt  <= h_lat - 1'b1;
            end else if (hcnt != '0) begin
               hcnt <= hcnt - 1'b1;
            end else begin
               if (bus.y_in != exp_y) begin
                  mis <= mis + 1'b1;
                  if (!fvld) begin
                     fvld <= 1'b1;
                     fidx <= rd_ptr;
                  end
               end
               if (!last) begin
                  rd_ptr <= rd_nxt;
                  xo     <= mem[rd_nxt][XW+YW-1:YW];
                  hcnt   <= h_lat - 1'b1;
               end
            end
         end
      end
   end

   assign bus.x_out    = xo;
   assign bus.full     = full;
   assign bus.count    = cnt;
   assign bus.busy     = (state == S_RUN);
   assign bus.done     = (state == S_DONE);
   assign bus.mis_cnt  = mis;
   assign bus.fail_vld = fvld;
   assign bus.fail_idx = fidx;
endmodule

// File: tb/tb_checker9_stim.sv
module tb_checker9_stim;
   localparam int XW = 10, YW = 11, DEPTH = 16, AW = 4, HW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   checker9_stim_if #(.XW(XW), .YW(YW), .AW(AW), .HW(HW)) bus();

   checker9_stim #(.XW(XW), .YW(YW), .DEPTH(DEPTH), .AW(AW), .HW(HW)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus.slave)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      bit            chk_x;
      logic [XW-1:0] x;
      bit            busy;
      bit            done;
      bit            chk_res;
      int            mis;
      bit            fv;
      int            fidx;
   } exp_t;

   exp_t sbq[$];
   logic [XW-1:0] mx[$];
   logic [YW-1:0] my[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int c, input bit cx, input logic [XW-1:0] x, input bit b,
                           input bit d, input bit cr, input int m, input bit fv, input int fi);
      exp_t e;
      e.cyc = c; e.chk_x = cx; e.x = x; e.busy = b; e.done = d;
      e.chk_res = cr; e.mis = m; e.fv = fv; e.fidx = fi;
      sbq.push_back(e);
   endtask

   // monitor: compare every output snapshot the scoreboard expects at this cycle
   exp_t me;
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         me = sbq.pop_front();
         if (me.cyc < cyc) chk("sb_stale_cycle", cyc, me.cyc);
         if (me.chk_x) chk("x_out", bus.x_out, me.x);
         chk("busy", bus.busy, me.busy);
         chk("done", bus.done, me.done);
         if (me.chk_res) begin
            chk("mis_cnt", bus.mis_cnt, me.mis);
            chk("fail_vld", bus.fail_vld, me.fv);
            chk("fail_idx", bus.fail_idx, me.fidx);
         end
      end
   end

   task automatic do_clr();
      @(negedge clk); bus.clr = 1'b1;
      @(negedge clk); bus.clr = 1'b0;
      mx.delete(); my.delete();
   endtask

   task automatic do_wr(input logic [XW-1:0] x, input logic [YW-1:0] y);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_x = x; bus.wr_y = y;
      if (mx.size() < DEPTH) begin mx.push_back(x); my.push_back(y); end
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic load_rand(input int n);
      for (int i = 0; i < n; i++) do_wr(XW'($urandom), YW'($urandom));
   endtask

   // full replay with expectations computed from the vector-window arithmetic
   task automatic run(input int hold_in, input logic [DEPTH-1:0] bad, input bit wr_during);
      int n, h, e0, e1, k, mis, fidx;
      bit seen;
      n = mx.size();
      h = (hold_in == 0) ? 1 : hold_in;
      mis = 0; fidx = 0; seen = 0;
      for (int i = 0; i < n; i++)
         if (bad[i]) begin
            mis++;
            if (!seen) begin fidx = i; seen = 1; end
         end
      @(negedge clk);
      bus.start = 1'b1; bus.hold = HW'(hold_in);
      if (wr_during) begin bus.wr_en = 1'b1; bus.wr_x = XW'($urandom); bus.wr_y = YW'($urandom); end
      e0 = cyc + 1;
      e1 = e0 + 1;
      if (n == 0) begin
         push_exp(e0, 0, '0, 0, 1, 1, 0, 0, 0);
         push_exp(e0 + 1, 0, '0, 0, 1, 1, 0, 0, 0);
      end else begin
         push_exp(e0, 0, '0, 1, 0, 1, 0, 0, 0);
         for (int j = 0; j < n * h; j++) push_exp(e1 + j, 1, mx[j / h], 1, 0, 0, 0, 0, 0);
         push_exp(e1 + n * h, 1, mx[n - 1], 0, 1, 1, mis, mis > 0, fidx);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.hold = HW'($urandom);
      if (n == 0) begin
         @(negedge clk);
      end else begin
         for (int ed = e1; ed <= e1 + n * h; ed++) begin
            if (ed == e1) bus.y_in = YW'($urandom);
            else begin
               k = (ed - e1 - 1) / h;
               bus.y_in = my[k] ^ (bad[k] ? (YW'(1) << $urandom_range(YW - 1, 0)) : YW'(0));
            end
            @(negedge clk);
         end
      end
      bus.wr_en = 1'b0;
      if (wr_during) chk("count_after_run_wr", bus.count, n);
   endtask

   initial begin
      int n, tmo;
      logic [DEPTH-1:0] bad;
      bus.wr_en = 0; bus.wr_x = '0; bus.wr_y = '0; bus.clr = 0; bus.start = 0;
      bus.hold = '0; bus.y_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_x_out", bus.x_out, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_mis", bus.mis_cnt, 0);
      chk("rst_fvld", bus.fail_vld, 0);
      chk("rst_fidx", bus.fail_idx, 0);
      rst_n = 1'b1;

      // 3 entries, hold=1, all match; wr_en held through start/run is dropped
      load_rand(3);
      chk("count3", bus.count, 3);
      run(1, '0, 1);

      // 4 entries, hold=3, mismatches on 1 and 3
      do_clr();
      load_rand(4);
      run(3, 16'b1010, 0);

      // overflow: 17 writes
      do_clr();
      load_rand(15);
      chk("full_at15", bus.full, 0);
      load_rand(1);
      chk("full_at16", bus.full, 1);
      chk("count_at16", bus.count, 16);
      load_rand(1);
      chk("count_after17", bus.count, 16);
      chk("full_after17", bus.full, 1);
      run(1, 16'h8001, 1);

      // empty start
      do_clr();
      chk("clr_count", bus.count, 0);
      chk("clr_done", bus.done, 0);
      run(1, '0, 0);

      // clr during RUN at entry 2
      do_clr();
      for (int i = 0; i < 4; i++) do_wr(XW'(10'h100 + i), YW'(i));
      @(negedge clk); bus.start = 1'b1; bus.hold = HW'(2);
      @(negedge clk); bus.start = 1'b0;
      bus.y_in = '1;
      tmo = 0;
      while (bus.x_out !== mx[2] && tmo < 50) begin @(negedge clk); tmo++; end
      chk("clr_run_reach_x2", tmo < 50, 1);
      bus.clr = 1'b1;
      @(negedge clk); bus.clr = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_count", bus.count, 0);
      chk("abort_x_out", bus.x_out, mx[2]);
      chk("abort_mis", bus.mis_cnt, 0);
      repeat (6) @(negedge clk);
      chk("abort_x_hold", bus.x_out, mx[2]);
      chk("abort_mis_later", bus.mis_cnt, 0);
      chk("abort_fvld_later", bus.fail_vld, 0);
      mx.delete(); my.delete();

      // random runs, including replays of the same buffer from DONE
      for (int r = 0; r < 5; r++) begin
         do_clr();
         n = $urandom_range(DEPTH, 1);
         load_rand(n);
         bad = DEPTH'($urandom) & DEPTH'($urandom);
         run($urandom_range(5, 0), bad, 0);
         bad = DEPTH'($urandom);
         run($urandom_range(4, 0), bad, 0);
      end

      // reset mid-run
      do_clr();
      load_rand(3);
      run(2, 16'h7, 0);
      @(negedge clk); bus.start = 1'b1; bus.hold = HW'(2);
      @(negedge clk); bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_x_out", bus.x_out, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_count", bus.count, 0);
      chk("midrst_mis", bus.mis_cnt, 0);
      chk("midrst_fvld", bus.fail_vld, 0);
      chk("midrst_fidx", bus.fail_idx, 0);
      mx.delete(); my.delete();
      @(negedge clk); rst_n = 1'b1;
      load_rand(5);
      run(0, 16'b10100, 0);
      run(1, 16'b01000, 0);

      tmo = 0;
      while (sbq.size() != 0 && tmo < 20) begin @(negedge clk); tmo++; end
      chk("sb_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
